// File: rtl/axis_router_pkg.sv
// Shared types and constants for the AXI-Stream packet router.
// Holds the routing FSM encoding and the saturating drop-counter helper.
package axis_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } rt_state_e;

  localparam int DROP_CNT_W = 16;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_route_reg.sv
// Single-entry output register for the router: one beat plus its channel select.
// Handshake: a beat moves when valid && ready at a rising edge; in_ready is high when the entry is empty or draining.
module axis_route_reg
  import axis_router_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int USIZE = 1,
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic [USIZE-1:0] in_user,
  input  logic             in_last,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [USIZE-1:0] out_user,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel
);

  logic             valid_q, valid_d;
  logic [DSIZE-1:0] data_q, data_d;
  logic [USIZE-1:0] user_q, user_d;
  logic             last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    user_d  = user_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (in_valid && in_ready) begin
      // A load in the same cycle as a drain keeps valid high.
      valid_d = 1'b1;
      data_d  = in_data;
      user_d  = in_user;
      last_d  = in_last;
      sel_d   = in_sel;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      user_q  <= user_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_user  = user_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: rtl/axis_packet_router.sv
// Steers whole AXI-Stream packets from one slave port to one of NUM master ports by the
// first-beat tdest; packets for non-existent channels are swallowed and counted.
module axis_packet_router
  import axis_router_pkg::*;
#(
  parameter int NUM   = 2,
  parameter int DSIZE = 8,
  parameter int USIZE = 1,
  parameter int SEL_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [DSIZE-1:0]      s_tdata,
  input  logic [USIZE-1:0]      s_tuser,
  input  logic [SEL_W-1:0]      s_tdest,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [NUM*DSIZE-1:0]  m_tdata,
  output logic [NUM*USIZE-1:0]  m_tuser,
  output logic [NUM-1:0]        m_tlast,
  output logic [NUM-1:0]        m_tvalid,
  input  logic [NUM-1:0]        m_tready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy
);

  localparam logic [SEL_W:0] NUM_W = (SEL_W + 1)'(NUM);

  rt_state_e              state_q, state_d;
  logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic                   accept;
  logic                   dest_ok;
  logic                   reg_in_valid;
  logic                   reg_in_ready;
  logic [SEL_W-1:0]       reg_in_sel;
  logic                   out_valid;
  logic                   sel_ready;
  logic [DSIZE-1:0]       out_data;
  logic [USIZE-1:0]       out_user;
  logic                   out_last;
  logic [SEL_W-1:0]       out_sel;

  // Zero-extend so the range test also works when NUM is a power of two.
  assign dest_ok = ({1'b0, s_tdest} < NUM_W);

  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (out_sel == SEL_W'(i)) sel_ready = m_tready[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    drop_cnt_d   = drop_cnt_q;
    reg_in_valid = 1'b0;
    reg_in_sel   = cur_sel_q;
    s_tready     = (state_q == DROP) ? 1'b1 : reg_in_ready;
    accept       = s_tvalid && s_tready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dest_ok) begin
            reg_in_valid = 1'b1;
            reg_in_sel   = s_tdest;
            cur_sel_d    = s_tdest;
            if (!s_tlast) state_d = FWD;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            if (!s_tlast) state_d = DROP;
          end
        end
      end
      FWD: begin
        if (accept) begin
          reg_in_valid = 1'b1;
          if (s_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_sel_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  axis_route_reg #(
    .DSIZE(DSIZE),
    .USIZE(USIZE),
    .SEL_W(SEL_W)
  ) u_out_reg (
    .clk      (aclk),
    .rst      (rst),
    .in_valid (reg_in_valid),
    .in_ready (reg_in_ready),
    .in_data  (s_tdata),
    .in_user  (s_tuser),
    .in_last  (s_tlast),
    .in_sel   (reg_in_sel),
    .out_valid(out_valid),
    .out_ready(sel_ready),
    .out_data (out_data),
    .out_user (out_user),
    .out_last (out_last),
    .out_sel  (out_sel)
  );

  // Payload fans out to every channel; only the selected valid is raised.
  always_comb begin
    m_tvalid = '0;
    for (int i = 0; i < NUM; i++) begin
      m_tvalid[i] = out_valid && (out_sel == SEL_W'(i));
    end
  end

  assign m_tdata  = {NUM{out_data}};
  assign m_tuser  = {NUM{out_user}};
  assign m_tlast  = {NUM{out_last}};
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != IDLE) || out_valid;

endmodule
